// File: rtl/morse_pkg.sv
// Shared encodings and defaults for the morse character path.
package morse_pkg;

   localparam logic SYM_DOT  = 1'b0;
   localparam logic SYM_LINE = 1'b1;

   localparam int DEF_MAX_SYMBOLS = 5;
   localparam int DEF_GAP_CYCLES  = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } acc_state_t;

endpackage

// File: rtl/morse_gap_timer.sv
// Idle-gap counter: counts cycles without a symbol, saturating at GAP_CYCLES.
module morse_gap_timer #(
   parameter int GAP_CYCLES = 8
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(GAP_CYCLES + 1);

   logic [CNT_W-1:0] gap_cnt_q;
   logic [CNT_W-1:0] gap_cnt_d;

   always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (clear) begin
         gap_cnt_d = '0;
      end else if (enable && (gap_cnt_q != CNT_W'(GAP_CYCLES))) begin
         gap_cnt_d = gap_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         gap_cnt_q <= '0;
      end else begin
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // Terminal count is one short of the gap so the commit edge lands on the GAP-th idle cycle.
   assign expired = (gap_cnt_q == CNT_W'(GAP_CYCLES - 1));

endmodule

// File: rtl/morse_accumulator.sv
// Collects dot/line pulses into a morse character and holds it under valid/ready.
// state     | meaning
// S_IDLE    | no character in progress
// S_COLLECT | symbols arriving, gap timer running
// S_HOLD    | character committed, code_valid high until accepted
module morse_accumulator
   import morse_pkg::*;
#(
   parameter int MAX_SYMBOLS = DEF_MAX_SYMBOLS,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   localparam int LEN_W      = $clog2(MAX_SYMBOLS + 1)
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   ld_dot,
   input  logic                   ld_line,
   input  logic                   code_ready,
   output logic [MAX_SYMBOLS-1:0] code,
   output logic [LEN_W-1:0]       code_len,
   output logic                   code_valid,
   output logic                   sym_err,
   output logic                   overflow
);

   acc_state_t             state_q, state_d;
   logic [MAX_SYMBOLS-1:0] code_q, code_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic                   valid_q, valid_d;
   logic                   sym_err_q, sym_err_d;
   logic                   overflow_q, overflow_d;

   logic                   sym;
   logic                   sym_bit;
   logic [MAX_SYMBOLS-1:0] code_shift;
   logic [LEN_W-1:0]       len_inc;
   logic                   len_full;
   logic                   gap_clear;
   logic                   gap_en;
   logic                   gap_expired;

   assign sym        = ld_dot ^ ld_line;
   assign sym_bit    = ld_line ? SYM_LINE : SYM_DOT;
   assign code_shift = (code_q << 1) | MAX_SYMBOLS'(sym_bit);
   assign len_inc    = len_q + LEN_W'(1);
   assign len_full   = (len_inc == LEN_W'(MAX_SYMBOLS));

   assign gap_clear = sym || (state_q != S_COLLECT);
   assign gap_en    = (state_q == S_COLLECT) && !sym;

   morse_gap_timer #(
      .GAP_CYCLES(GAP_CYCLES)
   ) u_gap_timer (
      .clock  (clock),
      .resetn (resetn),
      .clear  (gap_clear),
      .enable (gap_en),
      .expired(gap_expired)
   );

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      len_d      = len_q;
      valid_d    = valid_q;
      sym_err_d  = ld_dot && ld_line;
      overflow_d = 1'b0;

      unique case (state_q)
         S_IDLE, S_COLLECT: begin
            if (sym) begin
               code_d = code_shift;
               len_d  = len_inc;
               if (len_full) begin
                  state_d = S_HOLD;
                  valid_d = 1'b1;
               end else begin
                  state_d = S_COLLECT;
               end
            end else if ((state_q == S_COLLECT) && gap_expired) begin
               state_d = S_HOLD;
               valid_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (code_ready) begin
               valid_d = 1'b0;
               // A symbol coinciding with acceptance opens the next character.
               if (sym) begin
                  code_d  = MAX_SYMBOLS'(sym_bit);
                  len_d   = LEN_W'(1);
                  state_d = (MAX_SYMBOLS == 1) ? S_HOLD : S_COLLECT;
                  valid_d = (MAX_SYMBOLS == 1);
               end else begin
                  code_d  = '0;
                  len_d   = '0;
                  state_d = S_IDLE;
               end
            end else if (sym) begin
               overflow_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            code_d  = '0;
            len_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q    <= S_IDLE;
         code_q     <= '0;
         len_q      <= '0;
         valid_q    <= 1'b0;
         sym_err_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         len_q      <= len_d;
         valid_q    <= valid_d;
         sym_err_q  <= sym_err_d;
         overflow_q <= overflow_d;
      end
   end

   assign code       = code_q;
   assign code_len   = len_q;
   assign code_valid = valid_q;
   assign sym_err    = sym_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_accumulator.sv
// Scoreboard bench for morse_accumulator: expected characters queued at stimulus time.
module tb_morse_accumulator;

   logic       clock = 1'b0;
   logic       resetn;
   logic       ld_dot;
   logic       ld_line;
   logic       code_ready;
   logic [4:0] code;
   logic [2:0] code_len;
   logic       code_valid;
   logic       sym_err;
   logic       overflow;

   typedef struct {
      logic [4:0] code;
      logic [2:0] len;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic prev_valid = 1'b0;

   morse_accumulator #(.MAX_SYMBOLS(5), .GAP_CYCLES(8)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .ld_dot    (ld_dot),
      .ld_line   (ld_line),
      .code_ready(code_ready),
      .code      (code),
      .code_len  (code_len),
      .code_valid(code_valid),
      .sym_err   (sym_err),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Compare each newly committed character against the head of the scoreboard.
   always @(negedge clock) begin
      if (code_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(code_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_code", 32'(code), 32'(e.code));
            chk("sb_len", 32'(code_len), 32'(e.len));
            chk("sb_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_valid = code_valid;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [4:0] c, input logic [2:0] l, input int at);
      exp_t e;
      e.code = c;
      e.len  = l;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic pulse(input logic d, input logic l);
      ld_dot  = d;
      ld_line = l;
      step();
      ld_dot  = 1'b0;
      ld_line = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!code_valid && n < 40) begin
         step();
         n++;
      end
      if (!code_valid) chk("valid_timeout", 32'(code_valid), 32'd1);
   endtask

   task automatic accept();
      code_ready = 1'b1;
      step();
      code_ready = 1'b0;
      chk("accept_valid", 32'(code_valid), 32'd0);
      chk("accept_len", 32'(code_len), 32'd0);
      chk("accept_code", 32'(code), 32'd0);
   endtask

   initial begin
      int t;
      int held;
      resetn     = 1'b1;
      ld_dot     = 1'b0;
      ld_line    = 1'b0;
      code_ready = 1'b0;
      step();
      step();
      resetn = 1'b0;
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_len", 32'(code_len), 32'd0);
      chk("rst_valid", 32'(code_valid), 32'd0);
      chk("rst_flags", {30'd0, sym_err, overflow}, 32'd0);
      step();

      // 1: dot, gap of one, line, then idle commit
      t = cyc;
      pulse(1'b1, 1'b0);
      step();
      push(5'b00001, 3'd2, t + 11);
      pulse(1'b0, 1'b1);
      chk("t1_len_mid", 32'(code_len), 32'd2);
      wait_valid();
      accept();
      chk("t1_state", 32'(dut.state_q), 32'd0);
      step();

      // 2: five dots back to back, commit without gap wait
      t = cyc;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) push(5'b00000, 3'd5, t + 5);
         pulse(1'b1, 1'b0);
      end
      chk("t2_valid_now", 32'(code_valid), 32'd1);
      accept();
      step();

      // 3: long hold, dropped symbol, later accept
      t = cyc;
      push(5'b00001, 3'd1, t + 9);
      pulse(1'b0, 1'b1);
      wait_valid();
      held = 0;
      for (int i = 0; i < 20; i++) begin
         code_ready = (i % 3 == 99);
         step();
         if (code_valid) held++;
      end
      chk("t3_hold_cycles", 32'(held), 32'd20);
      pulse(1'b0, 1'b1);
      chk("t3_overflow", 32'(overflow), 32'd1);
      chk("t3_code_frozen", 32'(code), 32'd1);
      chk("t3_len_frozen", 32'(code_len), 32'd1);
      chk("t3_valid_held", 32'(code_valid), 32'd1);
      step();
      chk("t3_overflow_pulse", 32'(overflow), 32'd0);
      accept();
      step();

      // 4: accept and new line symbol in the same cycle
      t = cyc;
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      push(5'b00010, 3'd3, t + 11);
      pulse(1'b1, 1'b0);
      wait_valid();
      code_ready = 1'b1;
      ld_line    = 1'b1;
      t = cyc;
      push(5'b00001, 3'd1, t + 9);
      step();
      code_ready = 1'b0;
      ld_line    = 1'b0;
      chk("t4_valid", 32'(code_valid), 32'd0);
      chk("t4_state", 32'(dut.state_q), 32'd1);
      chk("t4_code", 32'(code), 32'd1);
      chk("t4_len", 32'(code_len), 32'd1);
      chk("t4_overflow", 32'(overflow), 32'd0);
      wait_valid();
      accept();
      step();

      // 5: both pulses high mid-character; gap keeps counting from the dot
      t = cyc;
      push(5'b00000, 3'd1, t + 9);
      pulse(1'b1, 1'b0);
      step();
      step();
      pulse(1'b1, 1'b1);
      chk("t5_sym_err", 32'(sym_err), 32'd1);
      chk("t5_len", 32'(code_len), 32'd1);
      step();
      chk("t5_sym_err_pulse", 32'(sym_err), 32'd0);
      wait_valid();
      accept();
      step();

      // 6a: reset in S_COLLECT with three symbols
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      chk("t6_len3", 32'(code_len), 32'd3);
      resetn = 1'b1;
      step();
      resetn = 1'b0;
      chk("t6a_out", {22'd0, code, code_len, code_valid, sym_err, overflow}, 32'd0);
      chk("t6a_state", 32'(dut.state_q), 32'd0);
      repeat (12) step();

      // 6b: reset while holding
      t = cyc;
      push(5'b00001, 3'd1, t + 9);
      pulse(1'b0, 1'b1);
      wait_valid();
      resetn = 1'b1;
      step();
      resetn = 1'b0;
      chk("t6b_out", {22'd0, code, code_len, code_valid, sym_err, overflow}, 32'd0);
      chk("t6b_state", 32'(dut.state_q), 32'd0);
      repeat (3) step();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
